sk9822_rx_decoder: RTL

- Receive-side counterpart of the SK9822 LED SPI transmitter.
- Oversamples the cko/sdo pair in the fast system clock domain and checks frame structure: start frame, NUM_LED LED frames, end frame.
- Decodes each LED word into brightness and B/G/R fields.
- Used as a loopback monitor in the FPGA debug build and as the checker in the light_spi bench.

---
 rtl/sk9822_rx_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sk9822_rx_decoder.sv
// SK9822 link monitor: oversamples cko/sdo, checks start/LED/end frame structure
// and decodes each LED word into brightness and B/G/R fields.
module sk9822_rx_decoder #(
   parameter int NUM_LED     = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cko_i,
   input  logic                       sdo_i,
   output logic                       led_valid,
   output logic [$clog2(NUM_LED)-1:0] led_idx,
   output logic [4:0]                 led_bright,
   output logic [7:0]                 led_b,
   output logic [7:0]                 led_g,
   output logic [7:0]                 led_r,
   output logic                       frame_done,
   output logic                       frame_err,
   output logic [1:0]                 err_code
);
   localparam int IDX_W = $clog2(NUM_LED);
   localparam int CNT_W = $clog2(NUM_LED + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {HUNT, SOF, LED, EOFR} state_e;

   state_e           state_q;
   logic             cko_s1_q, cko_s2_q, cko_s3_q, sdo_s1_q, sdo_s2_q;
   logic [5:0]       zero_cnt_q;
   logic [31:0]      word_q;
   logic [4:0]       bit_cnt_q;
   logic [CNT_W-1:0] led_cnt_q;
   logic [TO_W-1:0]  idle_cnt_q;
   logic             word_rdy_q;

   logic             cko_edge, bit_in, in_frame, timeout;
   logic [CNT_W-1:0] led_cnt_d;

   assign cko_edge  = cko_s2_q & ~cko_s3_q;
   assign bit_in    = sdo_s2_q;
   assign in_frame  = (state_q == LED) || (state_q == EOFR);
   assign led_cnt_d = led_cnt_q + CNT_W'(1);
   // A cko edge in the terminal-count cycle keeps the frame alive.
   assign timeout   = in_frame && !cko_edge && !word_rdy_q &&
                      (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= HUNT;
         cko_s1_q   <= 1'b0;
         cko_s2_q   <= 1'b0;
         cko_s3_q   <= 1'b0;
         sdo_s1_q   <= 1'b0;
         sdo_s2_q   <= 1'b0;
         zero_cnt_q <= '0;
         word_q     <= '0;
         bit_cnt_q  <= '0;
         led_cnt_q  <= '0;
         idle_cnt_q <= '0;
         word_rdy_q <= 1'b0;
         led_valid  <= 1'b0;
         led_idx    <= '0;
         led_bright <= '0;
         led_b      <= '0;
         led_g      <= '0;
         led_r      <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         err_code   <= '0;
      end else begin
         cko_s1_q   <= cko_i;
         cko_s2_q   <= cko_s1_q;
         cko_s3_q   <= cko_s2_q;
         sdo_s1_q   <= sdo_i;
         sdo_s2_q   <= sdo_s1_q;
         led_valid  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         word_rdy_q <= 1'b0;
         idle_cnt_q <= (in_frame && !cko_edge) ? idle_cnt_q + TO_W'(1) : '0;

         if (timeout) begin
            frame_err  <= 1'b1;
            err_code   <= 2'd3;
            state_q    <= HUNT;
            zero_cnt_q <= '0;
         end else if (word_rdy_q) begin
            // Word assembled on the previous edge; judge it one cycle later.
            zero_cnt_q <= '0;
            if (state_q == LED) begin
               if (word_q[31:29] == 3'b111) begin
                  led_valid  <= 1'b1;
                  led_idx    <= led_cnt_q[IDX_W-1:0];
                  led_bright <= word_q[28:24];
                  led_b      <= word_q[23:16];
                  led_g      <= word_q[15:8];
                  led_r      <= word_q[7:0];
                  led_cnt_q  <= led_cnt_d;
                  if (led_cnt_d == CNT_W'(NUM_LED)) state_q <= EOFR;
               end else begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd1;
                  state_q   <= HUNT;
               end
            end else begin
               if (&word_q) begin
                  frame_done <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd2;
               end
               state_q <= HUNT;
            end
         end else if (cko_edge) begin
            case (state_q)
               HUNT: begin
                  if (bit_in) begin
                     zero_cnt_q <= '0;
                  end else begin
                     if (zero_cnt_q != 6'd32) zero_cnt_q <= zero_cnt_q + 6'd1;
                     if (zero_cnt_q == 6'd31) state_q <= SOF;
                  end
               end
               SOF: begin
                  if (bit_in) begin
                     word_q    <= 32'd1;
                     bit_cnt_q <= 5'd1;
                     led_cnt_q <= '0;
                     state_q   <= LED;
                  end
               end
               default: begin
                  word_q     <= {word_q[30:0], bit_in};
                  bit_cnt_q  <= bit_cnt_q + 5'd1;
                  word_rdy_q <= (bit_cnt_q == 5'd31);
               end
            endcase
         end
      end
   end
endmodule
